// File: rtl/ibex_pkg.sv
// Shared types and constants for the IF->ID skid stage.
package ibex_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
    logic        err_plus2;
  } fetch_entry_t;

  localparam logic [1:0]  INSTR_C_MASK    = 2'b11;
  localparam int unsigned FetchEntryWidth = $bits(fetch_entry_t);

  function automatic logic instr_is_compressed(input logic [31:0] instr);
    return instr[1:0] != INSTR_C_MASK;
  endfunction

endpackage

// File: rtl/ibex_if_id_skid_stage_if.sv
// Fetch-side stream, ID-side stream and counter control of the IF->ID stage.
interface ibex_if_id_skid_stage_if #(
  parameter int unsigned CntWidth = 32
);

  logic                flush_i;
  logic                fetch_valid_i;
  logic                fetch_ready_o;
  logic [31:0]         fetch_rdata_i;
  logic [31:0]         fetch_addr_i;
  logic                fetch_err_i;
  logic                fetch_err_plus2_i;
  logic                id_valid_o;
  logic                id_ready_i;
  logic [31:0]         id_instr_o;
  logic [31:0]         id_addr_o;
  logic [31:0]         id_pc_next_o;
  logic                id_is_compressed_o;
  logic                id_err_o;
  logic                id_err_plus2_o;
  logic                cnt_clear_i;
  logic [CntWidth-1:0] instr_cnt_o;

  // Environment side: prefetch buffer, ID stage and control.
  modport master (
    output flush_i, fetch_valid_i, fetch_rdata_i, fetch_addr_i, fetch_err_i,
           fetch_err_plus2_i, id_ready_i, cnt_clear_i,
    input  fetch_ready_o, id_valid_o, id_instr_o, id_addr_o, id_pc_next_o,
           id_is_compressed_o, id_err_o, id_err_plus2_o, instr_cnt_o
  );

  // Stage side.
  modport slave (
    input  flush_i, fetch_valid_i, fetch_rdata_i, fetch_addr_i, fetch_err_i,
           fetch_err_plus2_i, id_ready_i, cnt_clear_i,
    output fetch_ready_o, id_valid_o, id_instr_o, id_addr_o, id_pc_next_o,
           id_is_compressed_o, id_err_o, id_err_plus2_o, instr_cnt_o
  );

endinterface

// File: rtl/ibex_skid_buffer.sv
// Generic 2-slot buffer whose upstream ready is a flop; MAIN drives the output, SKID absorbs
// the one beat accepted while the downstream stalls.
module ibex_skid_buffer #(
  parameter int unsigned Width    = 66,
  parameter bit          ResetAll = 1'b0,
  parameter bit          FlushEn  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  logic             main_valid_reg, main_valid_next;
  logic             skid_valid_reg, skid_valid_next;
  logic             ready_reg;
  logic [Width-1:0] main_data_reg, main_data_next;
  logic [Width-1:0] skid_data_reg, skid_data_next;
  logic             flush_en, push, pop;

  assign flush_en = FlushEn & flush;
  assign push     = in_valid & ready_reg & ~flush_en;
  assign pop      = main_valid_reg & out_ready & ~flush_en;

  always_comb begin
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;
    main_data_next  = main_data_reg;
    skid_data_next  = skid_data_reg;
    if (flush_en) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (!main_valid_reg || pop) begin
      if (skid_valid_reg) begin
        // ready was low, so no push can race the skid refill
        main_valid_next = 1'b1;
        main_data_next  = skid_data_reg;
        skid_valid_next = 1'b0;
      end else begin
        main_valid_next = push;
        if (push) main_data_next = in_data;
      end
    end else if (push) begin
      skid_valid_next = 1'b1;
      skid_data_next  = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      ready_reg      <= 1'b1;
    end else begin
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      ready_reg      <= ~skid_valid_next;
    end
  end

  if (ResetAll) begin : g_data_rst
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        main_data_reg <= '0;
        skid_data_reg <= '0;
      end else begin
        main_data_reg <= main_data_next;
        skid_data_reg <= skid_data_next;
      end
    end
  end else begin : g_data_norst
    always_ff @(posedge clk) begin
      main_data_reg <= main_data_next;
      skid_data_reg <= skid_data_next;
    end
  end

  assign in_ready  = ready_reg;
  assign out_valid = main_valid_reg;
  assign out_data  = main_data_reg;

endmodule

// File: rtl/ibex_if_id_skid_stage.sv
// Registered IF->ID boundary: skid-buffered fetch stream plus compressed decode, next-PC
// and a saturating delivered-instruction counter.
module ibex_if_id_skid_stage
  import ibex_pkg::*;
#(
  parameter bit          ResetAll = 1'b0,
  parameter int unsigned CntWidth = 32
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  ibex_if_id_skid_stage_if.slave bus
);

  fetch_entry_t        in_entry, main_entry;
  logic                main_valid, is_c, show, pop;
  logic [CntWidth-1:0] cnt_reg, cnt_next;

  assign in_entry = '{rdata:     bus.fetch_rdata_i,
                      addr:      bus.fetch_addr_i,
                      err:       bus.fetch_err_i,
                      err_plus2: bus.fetch_err_plus2_i};

  ibex_skid_buffer #(
    .Width    (FetchEntryWidth),
    .ResetAll (ResetAll),
    .FlushEn  (1'b1)
  ) u_skid (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .flush     (bus.flush_i),
    .in_valid  (bus.fetch_valid_i),
    .in_ready  (bus.fetch_ready_o),
    .in_data   (in_entry),
    .out_valid (main_valid),
    .out_ready (bus.id_ready_i),
    .out_data  (main_entry)
  );

  // With reset data, decode of the zeroed slot would read as compressed; mask it while empty.
  assign show = main_valid | ~ResetAll;
  assign is_c = instr_is_compressed(main_entry.rdata);

  assign bus.id_valid_o         = main_valid;
  assign bus.id_addr_o          = main_entry.addr;
  assign bus.id_instr_o         = is_c ? {16'h0000, main_entry.rdata[15:0]} : main_entry.rdata;
  assign bus.id_is_compressed_o = show & is_c;
  assign bus.id_pc_next_o       = show ? main_entry.addr + (is_c ? 32'd2 : 32'd4) : 32'd0;
  assign bus.id_err_o           = main_entry.err;
  assign bus.id_err_plus2_o     = main_entry.err & main_entry.err_plus2;

  assign pop = main_valid & bus.id_ready_i & ~bus.flush_i;

  always_comb begin
    cnt_next = cnt_reg;
    if (bus.cnt_clear_i) begin
      cnt_next = '0;
    end else if (pop && (cnt_reg != {CntWidth{1'b1}})) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign bus.instr_cnt_o = cnt_reg;

endmodule

// File: tb/tb_ibex_if_id_skid_stage.sv
// Directed bench for ibex_if_id_skid_stage: vector table plus multi-cycle corner sequences.
module tb_ibex_if_id_skid_stage;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ibex_if_id_skid_stage_if #(.CntWidth(4)) bus ();

  ibex_if_id_skid_stage #(
    .ResetAll (1'b1),
    .CntWidth (4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] fv, rdata, addr, err, e2, rdy, flush, clr;
    logic [31:0] x_valid, x_ready, x_instr, x_addr, x_pc, x_c, x_err, x_e2, x_cnt;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(
    input logic [31:0] fv, rdata, addr, err, e2, rdy, flush, clr,
    input logic [31:0] xv, xr, xi, xa, xp, xc, xe, xe2, xcnt);
    vec_t v;
    v.fv = fv; v.rdata = rdata; v.addr = addr; v.err = err; v.e2 = e2;
    v.rdy = rdy; v.flush = flush; v.clr = clr;
    v.x_valid = xv; v.x_ready = xr; v.x_instr = xi; v.x_addr = xa; v.x_pc = xp;
    v.x_c = xc; v.x_err = xe; v.x_e2 = xe2; v.x_cnt = xcnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] fv, rdata, addr, err, e2, rdy, flush, clr);
    bus.fetch_valid_i     = fv[0];
    bus.fetch_rdata_i     = rdata;
    bus.fetch_addr_i      = addr;
    bus.fetch_err_i       = err[0];
    bus.fetch_err_plus2_i = e2[0];
    bus.id_ready_i        = rdy[0];
    bus.flush_i           = flush[0];
    bus.cnt_clear_i       = clr[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          exp_cnt;
    logic        exp_valid;
    logic        exp_pop;
    vec_t        v;

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",  32'(bus.id_valid_o), 0);
    check("rst_ready",  32'(bus.fetch_ready_o), 1);
    check("rst_cnt",    32'(bus.instr_cnt_o), 0);
    check("rst_addr",   bus.id_addr_o, 0);
    check("rst_instr",  bus.id_instr_o, 0);
    check("rst_pcnext", bus.id_pc_next_o, 0);
    check("rst_isc",    32'(bus.id_is_compressed_o), 0);
    check("rst_err",    32'(bus.id_err_o), 0);
    check("rst_e2",     32'(bus.id_err_plus2_o), 0);
    $display("reset: valid=%b ready=%b cnt=%0d", bus.id_valid_o, bus.fetch_ready_o, bus.instr_cnt_o);
    rst_n = 1'b1;

    //          fv rdata         addr          er e2 rdy fl clr | v r instr         addr          pc_next       c er e2 cnt
    // streaming
    vecs.push_back(mk(1, 32'h00000013, 32'h80,  0, 0, 1, 0, 0,  1, 1, 32'h00000013, 32'h80, 32'h84, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h00004501, 32'h84,  0, 0, 1, 0, 0,  1, 1, 32'h00004501, 32'h84, 32'h86, 1, 0, 0, 1));
    vecs.push_back(mk(1, 32'h00A00093, 32'h86,  0, 0, 1, 0, 0,  1, 1, 32'h00A00093, 32'h86, 32'h8A, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0,            0,       0, 0, 1, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 3));
    // backpressure: 3 offered, 2 accepted, then release
    vecs.push_back(mk(1, 32'h11111113, 32'h100, 0, 0, 0, 0, 0,  1, 1, 32'h11111113, 32'h100, 32'h104, 0, 0, 0, 3));
    vecs.push_back(mk(1, 32'h22222223, 32'h104, 0, 0, 0, 0, 0,  1, 0, 32'h11111113, 32'h100, 32'h104, 0, 0, 0, 3));
    vecs.push_back(mk(1, 32'h33333333, 32'h108, 0, 0, 0, 0, 0,  1, 0, 32'h11111113, 32'h100, 32'h104, 0, 0, 0, 3));
    vecs.push_back(mk(1, 32'h33333333, 32'h108, 0, 0, 1, 0, 0,  1, 1, 32'h22222223, 32'h104, 32'h108, 0, 0, 0, 4));
    vecs.push_back(mk(1, 32'h33333333, 32'h108, 0, 0, 1, 0, 0,  1, 1, 32'h33333333, 32'h108, 32'h10C, 0, 0, 0, 5));
    vecs.push_back(mk(0, 0,            0,       0, 0, 1, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 6));
    // errors, compressed upper-half masking, pc wrap
    vecs.push_back(mk(1, 32'h0000FFFF, 32'hFE,  1, 1, 0, 0, 0,  1, 1, 32'h0000FFFF, 32'hFE,  32'h102, 0, 1, 1, 6));
    vecs.push_back(mk(1, 32'h00004501, 32'h102, 0, 1, 1, 0, 0,  1, 1, 32'h00004501, 32'h102, 32'h104, 1, 0, 0, 7));
    vecs.push_back(mk(1, 32'hDEAD8001, 32'h104, 0, 0, 1, 0, 0,  1, 1, 32'h00008001, 32'h104, 32'h106, 1, 0, 0, 8));
    vecs.push_back(mk(0, 0,            0,       0, 0, 1, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 9));
    vecs.push_back(mk(1, 32'h00000013, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 1, 1, 32'h00000013, 32'hFFFFFFFC, 32'h0, 0, 0, 0, 9));
    vecs.push_back(mk(0, 0,            0,       0, 0, 1, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 10));
    // flush with both slots full and a beat offered
    vecs.push_back(mk(1, 32'h44444413, 32'h200, 0, 0, 0, 0, 0,  1, 1, 32'h44444413, 32'h200, 32'h204, 0, 0, 0, 10));
    vecs.push_back(mk(1, 32'h55555513, 32'h204, 0, 0, 0, 0, 0,  1, 0, 32'h44444413, 32'h200, 32'h204, 0, 0, 0, 10));
    vecs.push_back(mk(1, 32'h66666613, 32'h208, 0, 0, 1, 1, 0,  0, 1, 0, 0, 0, 0, 0, 0, 10));
    vecs.push_back(mk(0, 0,            0,       0, 0, 1, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 10));
    vecs.push_back(mk(1, 32'h77777713, 32'h20C, 0, 0, 1, 1, 0,  0, 1, 0, 0, 0, 0, 0, 0, 10));
    vecs.push_back(mk(0, 0,            0,       0, 0, 1, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 10));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.fv, v.rdata, v.addr, v.err, v.e2, v.rdy, v.flush, v.clr);
      tick();
      check($sformatf("v%0d_valid", i), 32'(bus.id_valid_o), v.x_valid);
      check($sformatf("v%0d_ready", i), 32'(bus.fetch_ready_o), v.x_ready);
      check($sformatf("v%0d_cnt", i),   32'(bus.instr_cnt_o), v.x_cnt);
      if (v.x_valid[0]) begin
        check($sformatf("v%0d_instr", i),  bus.id_instr_o, v.x_instr);
        check($sformatf("v%0d_addr", i),   bus.id_addr_o, v.x_addr);
        check($sformatf("v%0d_pcnext", i), bus.id_pc_next_o, v.x_pc);
        check($sformatf("v%0d_isc", i),    32'(bus.id_is_compressed_o), v.x_c);
        check($sformatf("v%0d_err", i),    32'(bus.id_err_o), v.x_err);
        check($sformatf("v%0d_e2", i),     32'(bus.id_err_plus2_o), v.x_e2);
      end
      $display("vec %0d: fv=%b rdy=%b flush=%b -> valid=%b ready=%b instr=%08h addr=%08h cnt=%0d",
               i, v.fv[0], v.rdy[0], v.flush[0], bus.id_valid_o, bus.fetch_ready_o,
               bus.id_instr_o, bus.id_addr_o, bus.instr_cnt_o);
    end

    // counter saturation: stream 10 beats, enough pops to pass 4'hF
    exp_cnt   = 10;
    exp_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive((i < 10) ? 1 : 0, 32'h00000013, 32'h400 + 32'(i * 4), 0, 0, 1, 0, 0);
      exp_pop = exp_valid;
      if (exp_pop) exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
      exp_valid = (i < 10);
      tick();
      check($sformatf("sat%0d_cnt", i),   32'(bus.instr_cnt_o), 32'(exp_cnt));
      check($sformatf("sat%0d_valid", i), 32'(bus.id_valid_o), 32'(exp_valid));
      $display("sat %0d: valid=%b cnt=%0d", i, bus.id_valid_o, bus.instr_cnt_o);
    end

    // clear coincident with a pop wins, counting resumes afterwards
    drive(1, 32'h00000013, 32'h500, 0, 0, 0, 0, 0);
    tick();
    check("clr_pre_cnt", 32'(bus.instr_cnt_o), 15);
    drive(1, 32'h00000013, 32'h504, 0, 0, 1, 0, 1);
    tick();
    check("clr_cnt",   32'(bus.instr_cnt_o), 0);
    check("clr_valid", 32'(bus.id_valid_o), 1);
    check("clr_addr",  bus.id_addr_o, 32'h504);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    check("clr_post_cnt", 32'(bus.instr_cnt_o), 1);
    $display("clear: cnt=%0d valid=%b", bus.instr_cnt_o, bus.id_valid_o);

    // asynchronous reset mid-cycle with both slots full
    drive(1, 32'h88888813, 32'h600, 0, 0, 0, 0, 0);
    tick();
    drive(1, 32'h99999913, 32'h604, 0, 0, 0, 0, 0);
    tick();
    check("ar_pre_valid", 32'(bus.id_valid_o), 1);
    check("ar_pre_ready", 32'(bus.fetch_ready_o), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(bus.id_valid_o), 0);
    check("ar_ready", 32'(bus.fetch_ready_o), 1);
    check("ar_addr",  bus.id_addr_o, 0);
    check("ar_cnt",   32'(bus.instr_cnt_o), 0);
    $display("async reset: valid=%b ready=%b addr=%08h", bus.id_valid_o, bus.fetch_ready_o, bus.id_addr_o);
    #3;
    rst_n = 1'b1;
    tick();
    check("ar_post_valid", 32'(bus.id_valid_o), 0);
    check("ar_post_ready", 32'(bus.fetch_ready_o), 1);
    drive(1, 32'h00000013, 32'h700, 0, 0, 0, 0, 0);
    tick();
    check("ar_resume_valid", 32'(bus.id_valid_o), 1);
    check("ar_resume_addr",  bus.id_addr_o, 32'h700);
    $display("resume: valid=%b addr=%08h", bus.id_valid_o, bus.id_addr_o);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
